sync_fifo_rd_port: RTL and testbench

Read-side controller for the single-clock FIFO core. It reads from the simple dual-port RAM's registered read port (one-cycle read latency) using the writer's extended write pointer. It presents the words as a first-word-fall-through valid/ready stream at one word per cycle. It owns the read pointer and returns it to the write side for full detection.

---
 rtl/sync_fifo_rd_port.sv | 134 +++++++++++++
 tb/tb_sync_fifo_rd_port.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_rd_port.sv
// sync_fifo_rd_port: FIFO read side, FWFT stream from a 1-cycle RAM.
// Optional level_o output enabled by SYNC_FIFO_RD_LEVEL_EN.
module sync_fifo_rd_port #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_ADDR_WIDTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [P_ADDR_WIDTH:0]   wr_ptr_i,
  input  logic                    clear_i,
  output logic [P_ADDR_WIDTH:0]   rd_ptr_o,
  output logic                    ram_rd_o,
  output logic [P_ADDR_WIDTH-1:0] ram_addr_o,
  input  logic [P_DATA_WIDTH-1:0] ram_data_i,
  output logic [P_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
`ifdef SYNC_FIFO_RD_LEVEL_EN
  ,
  output logic [P_ADDR_WIDTH+1:0] level_o
`endif
);

  localparam int LW = P_ADDR_WIDTH + 2;

  logic [P_ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [P_DATA_WIDTH-1:0] head_q, head_d;
  logic [P_DATA_WIDTH-1:0] skid_q, skid_d;
  logic [1:0]              occ_q, occ_d;
  logic                    inf_q, inf_d;
  logic                    valid_q, valid_d;

  logic       non_empty;
  logic       pop;
  logic       issue;
  logic [1:0] cnt;

  assign non_empty = (rd_ptr_q != wr_ptr_i);
  assign pop       = valid_q & m_ready_i;
  assign cnt       = occ_q + {1'b0, inf_q};

  // Issue a read while the buffer plus in-flight word has room.
  assign issue = rst_ni & ~clear_i & non_empty &
                 ((cnt < 2'd2) | ((cnt == 2'd2) & pop));

  assign ram_rd_o   = issue;
  assign ram_addr_o = rd_ptr_q[P_ADDR_WIDTH-1:0];
  assign rd_ptr_o   = rd_ptr_q;
  assign m_data_o   = head_q;
  assign m_valid_o  = valid_q;

  // Next state of pointer, head/skid buffer and in-flight flag.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    head_d   = head_q;
    skid_d   = skid_q;
    occ_d    = occ_q;
    inf_d    = inf_q;
    if (clear_i) begin
      rd_ptr_d = wr_ptr_i;
      occ_d    = 2'd0;
      inf_d    = 1'b0;
    end else begin
      rd_ptr_d = rd_ptr_q + {{P_ADDR_WIDTH{1'b0}}, issue};
      inf_d    = issue;
      if (inf_q) begin
        if (occ_q == 2'd0 || (pop && occ_q == 2'd1)) begin
          head_d = ram_data_i;
          occ_d  = 2'd1;
        end else if (pop && occ_q == 2'd2) begin
          head_d = skid_q;
          skid_d = ram_data_i;
          occ_d  = 2'd2;
        end else begin
          skid_d = ram_data_i;
          occ_d  = 2'd2;
        end
      end else if (pop) begin
        if (occ_q == 2'd2) begin
          head_d = skid_q;
          occ_d  = 2'd1;
        end else begin
          occ_d  = 2'd0;
        end
      end
    end
    valid_d = (occ_d != 2'd0);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      head_q   <= '0;
      skid_q   <= '0;
      occ_q    <= 2'd0;
      inf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
      skid_q   <= skid_d;
      occ_q    <= occ_d;
      inf_q    <= inf_d;
      valid_q  <= valid_d;
    end
  end

`ifdef SYNC_FIFO_RD_LEVEL_EN
  logic [LW-1:0]         level_q, level_d;
  logic [P_ADDR_WIDTH:0] diff;

  assign diff    = wr_ptr_i - rd_ptr_q;
  assign level_o = level_q;

  // Unread words: RAM backlog plus in-flight plus buffered.
  always_comb begin
    level_d = LW'(diff) + LW'(occ_q) + LW'(inf_q);
    if (clear_i) begin
      level_d = '0;
    end
  end

  // Level register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_rd_port.sv
// tb_sync_fifo_rd_port: directed bench for the FIFO read port.
// Models the RAM and the write side; checks stream order and timing.
module tb_sync_fifo_rd_port;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] wr_ptr;
  logic       clear;
  logic [4:0] rd_ptr;
  logic       ram_rd;
  logic [3:0] ram_addr;
  logic [7:0] ram_q;
  logic [7:0] m_data;
  logic       m_valid;
  logic       ready;
`ifdef SYNC_FIFO_RD_LEVEL_EN
  logic [5:0] level;
`endif

  logic [7:0] mem [16];

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_rd) ram_q <= mem[ram_addr];
  end

  sync_fifo_rd_port #(
    .P_DATA_WIDTH(8),
    .P_ADDR_WIDTH(4)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wr_ptr_i  (wr_ptr),
    .clear_i   (clear),
    .rd_ptr_o  (rd_ptr),
    .ram_rd_o  (ram_rd),
    .ram_addr_o(ram_addr),
    .ram_data_i(ram_q),
    .m_data_o  (m_data),
    .m_valid_o (m_valid),
    .m_ready_i (ready)
`ifdef SYNC_FIFO_RD_LEVEL_EN
    ,
    .level_o   (level)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    wr_ptr = 5'd0;
    clear  = 1'b0;
    ready  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    wr_ptr = 5'd5;
    clear  = 1'b0;
    ready  = 1'b0;
    for (int i = 0; i < 5; i++) mem[i] = 8'h10 + 8'(i);
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (ram_rd !== 1'b0) begin
        errors++;
        $display("FAIL reset_rd c%0d: got %b expected 0", c, ram_rd);
      end
    end
    tick();
    rst_n = 1'b1;
    #1;
    vectors++;
    if ({rd_ptr, m_valid, m_data} !== {5'd0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_state: got ptr=%0d v=%b d=%h expected 0/0/00",
               rd_ptr, m_valid, m_data);
    end
    vectors++;
    if ({ram_rd, ram_addr} !== {1'b1, 4'd0}) begin
      errors++;
      $display("FAIL reset_first_rd: got rd=%b a=%0d expected 1/0",
               ram_rd, ram_addr);
    end
    tick();
    vectors++;
    if (rd_ptr !== 5'd1) begin
      errors++;
      $display("FAIL reset_ptr_adv: got %0d expected 1", rd_ptr);
    end
  endtask

  task automatic test_single();
    do_reset();
    mem[0] = 8'hA5;
    wr_ptr = 5'd1;
    ready  = 1'b1;
    #1;
    vectors++;
    if ({ram_rd, ram_addr} !== {1'b1, 4'd0}) begin
      errors++;
      $display("FAIL single_issue: got rd=%b a=%0d expected 1/0",
               ram_rd, ram_addr);
    end
    tick();
    vectors++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_c1: got v=%b expected 0", m_valid);
    end
    tick();
    vectors++;
    if ({m_valid, m_data} !== {1'b1, 8'hA5}) begin
      errors++;
      $display("FAIL single_c2: got v=%b d=%h expected 1/a5",
               m_valid, m_data);
    end
    tick();
    vectors++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_c3: got v=%b expected 0", m_valid);
    end
  endtask

  task automatic test_stream();
    int         exp;
    int         nw;
    logic [4:0] diff;
    do_reset();
    exp = 0;
    nw  = 0;
    for (int c = 0; c < 200 && exp < 40; c++) begin
      diff = wr_ptr - rd_ptr;
      if (nw < 40 && diff < 5'd16) begin
        mem[wr_ptr[3:0]] = 8'(nw);
        wr_ptr = wr_ptr + 5'd1;
        nw++;
      end
      ready = 1'b1;
      #1;
      if (m_valid) begin
        vectors++;
        if (m_data !== 8'(exp)) begin
          errors++;
          $display("FAIL stream_data: got %0d expected %0d", m_data, exp);
        end
        exp++;
      end else if (exp > 0) begin
        vectors++;
        errors++;
        $display("FAIL stream_gap: got v=0 expected 1 at word %0d", exp);
      end
      tick();
    end
    vectors++;
    if (exp != 40) begin
      errors++;
      $display("FAIL stream_count: got %0d expected 40", exp);
    end
    vectors++;
    if (rd_ptr !== 5'd8) begin
      errors++;
      $display("FAIL stream_ptr: got %0d expected 8", rd_ptr);
    end
  endtask

  task automatic test_backpressure();
    int rdcnt;
    int got;
    do_reset();
    for (int i = 0; i < 6; i++) mem[i] = 8'h60 + 8'(i);
    wr_ptr = 5'd6;
    ready  = 1'b0;
    rdcnt  = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (ram_rd) rdcnt++;
      if (c >= 2) begin
        vectors++;
        if ({m_valid, m_data} !== {1'b1, 8'h60}) begin
          errors++;
          $display("FAIL bp_hold c%0d: got v=%b d=%h expected 1/60",
                   c, m_valid, m_data);
        end
      end
      tick();
    end
    vectors++;
    if (rdcnt != 2) begin
      errors++;
      $display("FAIL bp_reads: got %0d expected 2", rdcnt);
    end
    ready = 1'b1;
    got   = 0;
    for (int c = 0; c < 20 && got < 6; c++) begin
      #1;
      vectors++;
      if ({m_valid, m_data} !== {1'b1, 8'h60 + 8'(got)}) begin
        errors++;
        $display("FAIL bp_drain: got v=%b d=%h expected 1/%h",
                 m_valid, m_data, 8'h60 + 8'(got));
      end
      got++;
      tick();
    end
  endtask

  task automatic test_clear();
    bit seen;
    do_reset();
    for (int i = 0; i < 6; i++) mem[i] = 8'h60 + 8'(i);
    wr_ptr = 5'd6;
    ready  = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    ready = 1'b1;
    tick();
    clear  = 1'b1;
    wr_ptr = 5'd20;
    #1;
    vectors++;
    if (ram_rd !== 1'b0) begin
      errors++;
      $display("FAIL clr_no_rd: got %b expected 0", ram_rd);
    end
    tick();
    clear = 1'b0;
    #1;
    vectors++;
    if ({m_valid, rd_ptr, ram_rd} !== {1'b0, 5'd20, 1'b0}) begin
      errors++;
      $display("FAIL clr_state: got v=%b p=%0d rd=%b expected 0/20/0",
               m_valid, rd_ptr, ram_rd);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      vectors++;
      if (m_valid !== 1'b0) begin
        errors++;
        $display("FAIL clr_discard c%0d: got v=%b d=%h expected v=0",
                 c, m_valid, m_data);
      end
    end
    mem[4] = 8'h77;
    wr_ptr = 5'd21;
    seen   = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      #1;
      if (m_valid) begin
        seen = 1'b1;
        vectors++;
        if (m_data !== 8'h77) begin
          errors++;
          $display("FAIL clr_next: got %h expected 77", m_data);
        end
      end
      tick();
    end
    if (!seen) begin
      vectors++;
      errors++;
      $display("FAIL clr_timeout: got no valid expected 77");
    end
  endtask

`ifdef SYNC_FIFO_RD_LEVEL_EN
  task automatic test_level();
    do_reset();
    #1;
    vectors++;
    if (level !== 6'd0) begin
      errors++;
      $display("FAIL lvl_reset: got %0d expected 0", level);
    end
    for (int i = 0; i < 3; i++) mem[i] = 8'h30 + 8'(i);
    wr_ptr = 5'd3;
    ready  = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    vectors++;
    if (level !== 6'd3) begin
      errors++;
      $display("FAIL lvl_three: got %0d expected 3", level);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    vectors++;
    if (level !== 6'd2) begin
      errors++;
      $display("FAIL lvl_pop: got %0d expected 2", level);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    vectors++;
    if (level !== 6'd0) begin
      errors++;
      $display("FAIL lvl_clear: got %0d expected 0", level);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_clear();
`ifdef SYNC_FIFO_RD_LEVEL_EN
    test_level();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
